fp32_operand_join: RTL and testbench
====================================

Name: fp32_operand_join

Overview:
- Upstream stage of the FP32 adder.
- Joins the two independent operand streams A and B into one paired, registered operand stream using valid/ready.
- Optionally flushes subnormals to zero and orders the pair by magnitude, so the adder's align stage always shifts the second operand.
- Contains a 2-entry buffer, which gives full throughput while keeping the input ready signals independent of the downstream ready.

Parameters:
- FTZ, 0: when 1, a subnormal input (exp==0, mant!=0) is replaced by a zero of the same sign before buffering.
- SWAP_EN, 1: when 1, the output pair is ordered so that o_a has magnitude (bits[30:0]) greater than or equal to o_b.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  32  operand A, IEEE-754 binary32.
- a_valid  input  1  A holds valid data.
- a_ready  output  1  A accepted in this cycle when a_valid && a_ready.
- b  input  32  operand B.
- b_valid  input  1  B holds valid data.
- b_ready  output  1  B accepted in this cycle when b_valid && b_ready.
- o_a  output  32  first operand of the buffered pair (larger magnitude when SWAP_EN=1).
- o_b  output  32  second operand of the buffered pair.
- o_swap  output  1  1 when the pair was exchanged (o_a came from B); always 0 when SWAP_EN=0.
- o_valid  output  1  head of the buffer holds a pair.
- o_ready  input  1  downstream adder accepts the head pair.

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset (takes effect at the edge where rst=1):
  - count=0, wr_ptr=0, rd_ptr=0.
  - o_valid=0, o_a=0, o_b=0, o_swap=0.
  - Any pair held in the buffer is discarded.
  - While rst=1, a_ready=0 and b_ready=0 regardless of count.
- Storage: 2-entry circular buffer with 1-bit wr_ptr and rd_ptr and a 2-bit count (0..2). Each entry holds {a_val, b_val, swap}. Pointers wrap 1 to 0.
- Join rule:
  - space = (count != 2).
  - a_ready = space && b_valid; b_ready = space && a_valid.
  - push = a_valid && b_valid && space. A and B are only ever consumed in the same cycle; a lone valid operand waits with its ready low.
  - The input readies never depend combinationally on o_ready.
- Pop and output:
  - pop = o_valid && o_ready.
  - o_valid = (count != 0). o_a, o_b and o_swap are driven from entry[rd_ptr], so they are registered outputs.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
  - When full, a push in the same cycle as a pop is not possible, because space is computed from the current count.
- Latency: a pair accepted at edge N is visible on o_valid after edge N (one cycle). Sustained throughput is 1 pair per cycle when o_ready=1.
- Output hold: while o_valid=1 and o_ready=0, o_a, o_b and o_swap must stay stable.
- Canonicalisation (applied in the push cycle, in this order):
  1. FTZ=1: each subnormal operand becomes {sign, 31'b0}. NaN and Inf pass through unchanged.
  2. SWAP_EN=1: swap = (b[30:0] > a[30:0]) as an unsigned compare on the post-FTZ values.
     - Equal magnitudes: no swap.
     - NaN payloads compare as raw bits, with no special handling.
- Signs are never altered except by the FTZ sign-preserving flush.

Optional Feature:
- Macro: FP_JOIN_CLASS_EN.
- Defined:
  - Adds outputs o_cls_a [2:0] and o_cls_b [2:0], stored per entry alongside the data and aligned with o_a and o_b.
  - Classification is computed after FTZ and after the swap.
  - Encoding: 0 zero, 1 subnormal, 2 normal, 3 inf, 4 quiet NaN (mant[22]=1), 5 signalling NaN (exp=255, mant!=0, mant[22]=0).
  - Both class outputs reset to 0.
- Not defined: the ports do not exist and no classification logic is built.

Test Plan:
- Reset then a=0x3F800000 and b=0x40000000 valid together, o_ready=1 (default parameters) -> both readies 1 in that cycle; next cycle o_valid=1, o_a=0x40000000, o_b=0x3F800000, o_swap=1.
- a_valid=1 held for 3 cycles with b_valid=0, then b_valid=1 -> a_ready=0 for those 3 cycles; exactly one pair is pushed; o_valid asserts one cycle after b arrives.
- o_ready=0 with 3 consecutive pairs offered -> first two pairs accepted (count=2); third cycle a_ready=b_ready=0; the head pair holds stable. o_ready=1 -> pairs drain in order and the third is then accepted.
- FTZ=1, a=0x80000001, b=0x00400000 -> o_a=0x80000000, o_b=0x00000000, o_swap=0; with FP_JOIN_CLASS_EN defined, o_cls_a=o_cls_b=0.
- Streaming 10 pairs with o_ready=1 every cycle -> o_valid continuously 1 from cycle 1; count never exceeds 1; output order preserved.
- count=2 and o_valid=1, then rst=1 for one cycle -> next cycle o_valid=0, count=0, o_a=o_b=0; readies are 0 during rst and return to join behaviour afterwards.

Source files
------------

// File: rtl/fp32_operand_join.sv
// Joins operand streams A and B into one registered pair stream through a 2-entry buffer,
// with optional subnormal flush and magnitude ordering. Define FP_JOIN_CLASS_EN to add per-operand class outputs.
module fp32_operand_join #(
  parameter bit FTZ     = 1'b0,
  parameter bit SWAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [31:0] b,
  input  logic        b_valid,
  output logic        b_ready,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic        o_swap,
`ifdef FP_JOIN_CLASS_EN
  output logic [2:0]  o_cls_a,
  output logic [2:0]  o_cls_b,
`endif
  output logic        o_valid,
  input  logic        o_ready
);

  logic [1:0]       r_count;
  logic             r_wr_ptr, r_rd_ptr;
  logic [1:0][31:0] r_ea, r_eb;
  logic [1:0]       r_esw;

  logic        w_space, w_push, w_pop, w_swap;
  logic [31:0] w_a_f, w_b_f, w_a_in, w_b_in;

  assign w_space = (r_count != 2'd2);
  // Readies see only local state and the partner valid, never o_ready.
  assign a_ready = !rst && w_space && b_valid;
  assign b_ready = !rst && w_space && a_valid;
  assign w_push  = !rst && w_space && a_valid && b_valid;
  assign o_valid = (r_count != 2'd0);
  assign w_pop   = o_valid && o_ready;

  // Exp==0 flush also maps zero onto itself, so no mantissa test is needed.
  assign w_a_f  = (FTZ && a[30:23] == 8'd0) ? {a[31], 31'b0} : a;
  assign w_b_f  = (FTZ && b[30:23] == 8'd0) ? {b[31], 31'b0} : b;
  assign w_swap = SWAP_EN && (w_b_f[30:0] > w_a_f[30:0]);
  assign w_a_in = w_swap ? w_b_f : w_a_f;
  assign w_b_in = w_swap ? w_a_f : w_b_f;

  assign o_a    = r_ea[r_rd_ptr];
  assign o_b    = r_eb[r_rd_ptr];
  assign o_swap = r_esw[r_rd_ptr];

`ifdef FP_JOIN_CLASS_EN
  logic [1:0][2:0] r_cls_a, r_cls_b;

  function automatic logic [2:0] fp_cls(input logic [31:0] v);
    if (v[30:23] == 8'd0)        return (v[22:0] == 23'd0) ? 3'd0 : 3'd1;
    else if (v[30:23] == 8'hFF) begin
      if (v[22:0] == 23'd0)      return 3'd3;
      else                       return v[22] ? 3'd4 : 3'd5;
    end
    else                         return 3'd2;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls_a <= '0;
      r_cls_b <= '0;
    end else if (w_push) begin
      r_cls_a[r_wr_ptr] <= fp_cls(w_a_in);
      r_cls_b[r_wr_ptr] <= fp_cls(w_b_in);
    end
  end

  assign o_cls_a = r_cls_a[r_rd_ptr];
  assign o_cls_b = r_cls_b[r_rd_ptr];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_ea     <= '0;
      r_eb     <= '0;
      r_esw    <= '0;
    end else begin
      if (w_push) begin
        r_ea[r_wr_ptr]  <= w_a_in;
        r_eb[r_wr_ptr]  <= w_b_in;
        r_esw[r_wr_ptr] <= w_swap;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_operand_join.sv
// Directed bench for fp32_operand_join: join, backpressure, ordering, flush, streaming and reset.
module tb_fp32_operand_join;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        a_valid, b_valid, o_ready;
  logic        a_ready, b_ready, o_valid, o_swap;
  logic [31:0] o_a, o_b;
  logic        f_a_ready, f_b_ready, f_valid, f_swap;
  logic [31:0] f_a, f_b;
`ifdef FP_JOIN_CLASS_EN
  logic [2:0]  o_cls_a, o_cls_b, f_cls_a, f_cls_b;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp32_operand_join dut (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .b(b), .b_valid(b_valid), .b_ready(b_ready),
    .o_a(o_a), .o_b(o_b), .o_swap(o_swap),
`ifdef FP_JOIN_CLASS_EN
    .o_cls_a(o_cls_a), .o_cls_b(o_cls_b),
`endif
    .o_valid(o_valid), .o_ready(o_ready));

  fp32_operand_join #(.FTZ(1'b1), .SWAP_EN(1'b1)) dut_ftz (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .a_ready(f_a_ready),
    .b(b), .b_valid(b_valid), .b_ready(f_b_ready),
    .o_a(f_a), .o_b(f_b), .o_swap(f_swap),
`ifdef FP_JOIN_CLASS_EN
    .o_cls_a(f_cls_a), .o_cls_b(f_cls_b),
`endif
    .o_valid(f_valid), .o_ready(o_ready));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [31:0] ad, input logic bv, input logic [31:0] bd);
    a_valid = av; a = ad; b_valid = bv; b = bd;
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] ea, input logic [31:0] eb, input logic es);
    chk({tag, "_vld"}, 32'(o_valid), 32'd1);
    chk({tag, "_a"}, o_a, ea);
    chk({tag, "_b"}, o_b, eb);
    chk({tag, "_sw"}, 32'(o_swap), 32'(es));
  endtask

  initial begin
    rst = 1'b1; o_ready = 1'b1;
    drive(1'b1, 32'h3F800000, 1'b1, 32'h40000000);
    chk("rst_ardy", 32'(a_ready), 32'd0);
    chk("rst_brdy", 32'(b_ready), 32'd0);
    tick(); tick();
    chk("rst_vld", 32'(o_valid), 32'd0);
    chk("rst_oa", o_a, 32'd0);
    chk("rst_osw", 32'(o_swap), 32'd0);

    // basic join with swap: 1.0 / 2.0
    rst = 1'b0;
    drive(1'b1, 32'h3F800000, 1'b1, 32'h40000000);
    chk("t1_ardy", 32'(a_ready), 32'd1);
    chk("t1_brdy", 32'(b_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    head("t1", 32'h40000000, 32'h3F800000, 1'b1);
    tick();
    chk("t1_empty", 32'(o_valid), 32'd0);

    // lone A waits for B
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h40400000, 1'b0, 32'd0);
      chk("t2_ardy", 32'(a_ready), 32'd0);
      chk("t2_vld", 32'(o_valid), 32'd0);
      tick();
    end
    drive(1'b1, 32'h40400000, 1'b1, 32'h3F800000);
    chk("t2_ardy_b", 32'(a_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    head("t2", 32'h40400000, 32'h3F800000, 1'b0);
    tick();
    chk("t2_one", 32'(o_valid), 32'd0);

    // backpressure: fill to 2, third waits, then drain in order
    o_ready = 1'b0;
    drive(1'b1, 32'h3F800000, 1'b1, 32'h40000000);
    chk("t3_rdy0", 32'(a_ready), 32'd1);
    tick();
    drive(1'b1, 32'hC0A00000, 1'b1, 32'h40400000);
    chk("t3_rdy1", 32'(b_ready), 32'd1);
    head("t3_h0", 32'h40000000, 32'h3F800000, 1'b1);
    tick();
    drive(1'b1, 32'h00000000, 1'b1, 32'h80000000);
    chk("t3_full_a", 32'(a_ready), 32'd0);
    chk("t3_full_b", 32'(b_ready), 32'd0);
    head("t3_hold", 32'h40000000, 32'h3F800000, 1'b1);
    tick();
    head("t3_hold2", 32'h40000000, 32'h3F800000, 1'b1);
    o_ready = 1'b1;
    #1;
    chk("t3_noor", 32'(a_ready), 32'd0);
    tick();
    head("t3_h1", 32'hC0A00000, 32'h40400000, 1'b0);
    chk("t3_space", 32'(a_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    head("t3_h2", 32'h00000000, 32'h80000000, 1'b0);
    tick();
    chk("t3_empty", 32'(o_valid), 32'd0);

    // subnormal pair: FTZ=0 keeps and orders, FTZ=1 flushes to signed zeros (equal, no swap)
    drive(1'b1, 32'h80000001, 1'b1, 32'h00400000);
    tick();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    head("t4_noftz", 32'h00400000, 32'h80000001, 1'b1);
    chk("t4_f_vld", 32'(f_valid), 32'd1);
    chk("t4_f_a", f_a, 32'h80000000);
    chk("t4_f_b", f_b, 32'h00000000);
    chk("t4_f_sw", 32'(f_swap), 32'd0);
`ifdef FP_JOIN_CLASS_EN
    chk("t4_cls_a", 32'(o_cls_a), 32'd1);
    chk("t4_cls_b", 32'(o_cls_b), 32'd1);
    chk("t4_f_cls_a", 32'(f_cls_a), 32'd0);
    chk("t4_f_cls_b", 32'(f_cls_b), 32'd0);
`endif
    tick();

`ifdef FP_JOIN_CLASS_EN
    // classes: +inf vs qNaN (NaN larger, swapped), normal vs sNaN
    drive(1'b1, 32'h7F800000, 1'b1, 32'h7FC00000);
    tick();
    drive(1'b1, 32'h3F800000, 1'b1, 32'hFF800001);
    chk("t4_cls_q", 32'(o_cls_a), 32'd4);
    chk("t4_cls_i", 32'(o_cls_b), 32'd3);
    tick();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("t4_cls_s", 32'(o_cls_a), 32'd5);
    chk("t4_cls_n", 32'(o_cls_b), 32'd2);
    tick();
`endif

    // stream 10 pairs, odd ones swapped
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h41000000 + 32'(i), 1'b1,
            (i % 2 == 1) ? 32'h42000000 + 32'(i) : 32'h3F000000 + 32'(i));
      chk("t5_rdy", 32'(a_ready), 32'd1);
      if (i > 0) begin
        if ((i - 1) % 2 == 1) head("t5", 32'h42000000 + 32'(i - 1), 32'h41000000 + 32'(i - 1), 1'b1);
        else                  head("t5", 32'h41000000 + 32'(i - 1), 32'h3F000000 + 32'(i - 1), 1'b0);
      end
      tick();
    end
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    head("t5_last", 32'h42000009, 32'h41000009, 1'b1);
    tick();
    chk("t5_empty", 32'(o_valid), 32'd0);

    // reset while full
    o_ready = 1'b0;
    drive(1'b1, 32'h40800000, 1'b1, 32'h40A00000);
    tick(); tick();
    chk("t6_full", 32'(a_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_ardy", 32'(a_ready), 32'd0);
    chk("t6_rst_brdy", 32'(b_ready), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    chk("t6_vld", 32'(o_valid), 32'd0);
    chk("t6_oa", o_a, 32'd0);
    chk("t6_ob", o_b, 32'd0);
    chk("t6_sw", 32'(o_swap), 32'd0);
    drive(1'b1, 32'hC1200000, 1'b1, 32'h3F800000);
    chk("t6_ardy", 32'(a_ready), 32'd1);
    chk("t6_brdy", 32'(b_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 1'b0, 32'd0);
    head("t6_after", 32'hC1200000, 32'h3F800000, 1'b0);
    tick();
    chk("t6_held", 32'(o_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
